// File: rtl/threshold_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : threshold_ram_writer
// Description : Raster-order writer filling the 128x128 threshold frame buffer
//               from a valid/ready stream; address = {row, col}.
//               Optional frame checksum: define WRITER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module threshold_ram_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int COL_BITS   = 7,
    parameter int ROW_BITS   = 7
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iStart,
    input  logic                         iValid,
    input  logic [DATA_WIDTH-1:0]        iData,
    output logic                         oReady,
    output logic                         oWrEn,
    output logic [ROW_BITS+COL_BITS-1:0] oWrAddr,
    output logic [DATA_WIDTH-1:0]        oWrData,
    output logic                         oBusy,
    output logic                         oDone
`ifdef WRITER_CHECKSUM_EN
    ,
    output logic [15:0]                  oChecksum
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [COL_BITS-1:0] c_COL_MAX = {COL_BITS{1'b1}};
    localparam logic [ROW_BITS-1:0] c_ROW_MAX = {ROW_BITS{1'b1}};
    localparam logic [COL_BITS-1:0] c_COL_ONE = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] c_ROW_ONE = ROW_BITS'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [COL_BITS-1:0] r_col;
    logic [ROW_BITS-1:0] r_row;
    logic                w_accept;
    logic                w_last;

    assign w_accept = (r_state == c_ST_WRITE) && iValid;
    assign w_last   = (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        oReady       = 1'b0;
        oBusy        = 1'b0;
        oDone        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (iStart) begin
                    w_next_state = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                oReady = 1'b1;
                oBusy  = 1'b1;
                if (w_accept && w_last) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // The final registered write is on the port during this cycle
                oBusy        = 1'b1;
                oDone        = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Counters only move while writing; IDLE and DONE keep them parked at zero
    always_ff @(posedge clock) begin
        if (reset || (r_state != c_ST_WRITE)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + c_ROW_ONE;
            end else begin
                r_col <= r_col + c_COL_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oWrData <= '0;
        end else begin
            oWrEn <= w_accept;
            if (w_accept) begin
                oWrAddr <= {r_row, r_col};
                oWrData <= iData;
            end
        end
    end

`ifdef WRITER_CHECKSUM_EN
    logic [15:0] r_checksum;
    logic [15:0] w_data_ext;

    assign w_data_ext = 16'(iData);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum <= '0;
        end else if ((r_state == c_ST_IDLE) && iStart) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + w_data_ext;
        end
    end

    assign oChecksum = r_checksum;
`endif

endmodule
`default_nettype wire
